seq_datapath: RTL
=================

Name: seq_datapath

Overview:
- Parametrised, self-sequencing successor to the team's 4x8-bit register/ALU datapath.
- Accepts one register-transfer command per valid/ready handshake and runs the transfer through an internal temp register.
- Steps are sequenced by an FSM instead of external per-cycle controls: tmp load, ALU, writeback.
- Sits between a command sequencer (upstream) and any consumer of the designated output register.

Parameters:
- DATA_W, 8: register, tmp and ALU width in bits.
- NREGS, 4: number of general registers (2..16).
- OUT_REG, 0: index of the register continuously driven on out.
- IDX_W, $clog2(NREGS): register index width (localparam, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block is idle and can accept a command.
- cmd_op  in  3  opcode (see Behaviour).
- cmd_rd  in  IDX_W  destination register / first operand.
- cmd_rs  in  IDX_W  source register / second operand.
- cmd_imm  in  DATA_W  immediate for LDI.
- done  out  1  one-cycle pulse: command retired, result visible.
- err  out  1  valid only with done: illegal op or index out of range; no register written.
- out  out  DATA_W  R[OUT_REG].
- dbg_idx  in  IDX_W  debug read index.
- dbg_data  out  DATA_W  R[dbg_idx], combinational; 0 if dbg_idx >= NREGS.

Behaviour:
- Reset (async, rst_n=0):
  - All R[i] = 0 and tmp = 0.
  - FSM = IDLE; done = 0, err = 0, cmd_ready = 1 after reset release.
  - A reset mid-command aborts it with no writeback and no done pulse.
- Handshake:
  - cmd_ready = (state == IDLE).
  - A command is accepted on a rising edge where cmd_valid && cmd_ready; the op, rd, rs and imm fields are latched at that edge.
  - cmd_valid while busy is ignored; the upstream must hold it until accepted.
- Opcodes:
  - 000 LDI: R[rd] = imm.
  - 001 MOV: R[rd] = R[rs].
  - 010 XOR: R[rd] = R[rd] ^ R[rs].
  - 011 AND: R[rd] = R[rd] & R[rs].
  - 100 SHL: R[rd] = R[rd] << 1, zero fill, MSB discarded.
  - 101 ADD: optional, see below.
  - 110, 111: reserved.
- FSM states: IDLE, LOAD_T, EXEC, WB.
  - IDLE, accept of LDI: tmp <= imm, go to WB.
  - IDLE, accept of MOV: tmp <= R[rs], go to WB.
  - IDLE, accept of XOR/AND/SHL/ADD: go to LOAD_T.
  - IDLE, accept of a reserved op, or rd/rs >= NREGS: go to WB with an error flag set.
  - LOAD_T: tmp <= R[rd], go to EXEC.
  - EXEC: tmp <= alu(tmp, R[rs]), go to WB.
  - WB: R[rd] <= tmp unless the error flag is set; done <= 1 (registered); err <= error flag; go to IDLE.
- Latency (accept edge to first cycle done=1):
  - LDI/MOV/error: 2 edges.
  - ALU ops: 4 edges.
  - done and cmd_ready rise in the same cycle, so a back-to-back command may be accepted that edge.
- Arithmetic: all ops are DATA_W wide, with no sign extension and no saturation.
- Operand aliasing: rd == rs is legal (XOR Rx,Rx -> 0; AND Rx,Rx -> Rx).
- Operand timing: R[rs] is sampled in EXEC, not at accept. No other writer exists, so the value is unchanged.
- out follows R[OUT_REG] combinationally from the register, so it updates in the done cycle.

Optional Feature:
- Macro: SEQ_DATAPATH_ADD_EN.
- Defined:
  - op 101 ADD: R[rd] = R[rd] + R[rs] mod 2^DATA_W.
  - Extra output port carry (1 bit, reset 0) is written at WB of an ADD with the carry-out.
  - carry holds its value otherwise.
- Undefined:
  - op 101 is reserved (err path).
  - No carry port.

Decomposition:
- Package seq_datapath_pkg holds:
  - op_e enum with the 3-bit opcodes.
  - state_e enum (IDLE, LOAD_T, EXEC, WB).
  - An is_alu_op() function.
- Sub-module seq_datapath_alu: combinational, parameter DATA_W, inputs op/a/b, output result (plus carry under the macro).
- Register file and FSM stay in the top level.

Test Plan:
- Reset then LDI R2,0xA5 -> done 2 edges after accept, err=0, dbg R2=0xA5, all other registers 0.
- LDI R1,0x3C; LDI R3,0x0F; AND R1,R3 -> done 4 edges after the AND accept, R1=0x0C; then XOR R1,R1 -> R1=0x00.
- LDI R0,0x81; SHL R0 -> out=0x02 in the done cycle; cmd_valid held high during busy is accepted only when cmd_ready=1.
- Op 110 (and op 101 without the macro), plus NREGS=3 with rd=3 -> done=1, err=1, no register changes.
- Assert rst_n=0 during EXEC of XOR R2,R1 -> no done pulse, all registers 0, cmd_ready=1 after release.
- With SEQ_DATAPATH_ADD_EN: R1=0xF0, R2=0x20, ADD R1,R2 -> R1=0x10, carry=1; then ADD R1,R1 -> R1=0x20, carry=0.

Source files
------------

// File: rtl/seq_datapath_pkg.sv
// seq_datapath_pkg: shared types for the self-sequencing register/ALU datapath.
//   op_e      - 3-bit command opcodes
//   state_e   - sequencer FSM states
//   is_alu_op - true for ops that go through LOAD_T/EXEC
// Optional feature macro: SEQ_DATAPATH_ADD_EN (makes op 101 ADD legal).
package seq_datapath_pkg;

  typedef enum logic [2:0] {
    OP_LDI = 3'b000,
    OP_MOV = 3'b001,
    OP_XOR = 3'b010,
    OP_AND = 3'b011,
    OP_SHL = 3'b100,
    OP_ADD = 3'b101,
    OP_RS6 = 3'b110,
    OP_RS7 = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_T = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_e;

  function automatic logic is_alu_op(input op_e op);
    case (op)
      OP_XOR, OP_AND, OP_SHL: return 1'b1;
`ifdef SEQ_DATAPATH_ADD_EN
      OP_ADD:                 return 1'b1;
`endif
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seq_datapath_alu.sv
// seq_datapath_alu: combinational DATA_W-wide ALU.
//   op     in  op_e          operation
//   a      in  DATA_W        first operand (tmp, i.e. old R[rd])
//   b      in  DATA_W        second operand (R[rs])
//   result out DATA_W        a op b, truncated to DATA_W
//   carry  out 1             ADD carry-out (only with SEQ_DATAPATH_ADD_EN)
module seq_datapath_alu
  import seq_datapath_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  op_e               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
`ifdef SEQ_DATAPATH_ADD_EN
  output logic              carry,
`endif
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = a;
`ifdef SEQ_DATAPATH_ADD_EN
    carry  = 1'b0;
`endif
    case (op)
      OP_XOR: result = a ^ b;
      OP_AND: result = a & b;
      OP_SHL: result = a << 1;
`ifdef SEQ_DATAPATH_ADD_EN
      OP_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
`endif
      default: result = a;
    endcase
  end

endmodule

// File: rtl/seq_datapath.sv
// seq_datapath: register file plus ALU, one register-transfer command per
// valid/ready handshake, sequenced internally through a tmp register.
//   clk, rst_n        clock, async active-low reset
//   cmd_valid/ready   command handshake (ready only in IDLE)
//   cmd_op/rd/rs/imm  command fields, latched at accept
//   done, err         one-cycle retire pulse; err set for illegal op/index
//   out               R[OUT_REG]
//   dbg_idx/dbg_data  combinational debug read, 0 for out-of-range index
//   carry             ADD carry-out, only with SEQ_DATAPATH_ADD_EN
// Optional feature macro: SEQ_DATAPATH_ADD_EN.
module seq_datapath
  import seq_datapath_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int NREGS   = 4,
  parameter  int OUT_REG = 0,
  localparam int IDX_W   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [IDX_W-1:0]  cmd_rd,
  input  logic [IDX_W-1:0]  cmd_rs,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              done,
  output logic              err,
`ifdef SEQ_DATAPATH_ADD_EN
  output logic              carry,
`endif
  output logic [DATA_W-1:0] out,
  input  logic [IDX_W-1:0]  dbg_idx,
  output logic [DATA_W-1:0] dbg_data
);

  typedef logic [NREGS-1:0][DATA_W-1:0] rf_t;

  // Loop-compare read so an out-of-range index (NREGS not a power of 2)
  // never indexes past the array; it just returns 0.
  function automatic logic [DATA_W-1:0] rf_rd(input rf_t rf, input logic [IDX_W-1:0] idx);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < NREGS; i++)
      if (idx == IDX_W'(i)) v = rf[i];
    return v;
  endfunction

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return (int'(idx) < NREGS);
  endfunction

  state_e            state_q, state_d;
  rf_t               regs_q, regs_d;
  logic [DATA_W-1:0] tmp_q, tmp_d;
  op_e               op_q, op_d;
  logic [IDX_W-1:0]  rd_q, rd_d, rs_q, rs_d;
  logic              eflag_q, eflag_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] alu_res;
  op_e               cmd_op_e;
  logic              cmd_legal;
`ifdef SEQ_DATAPATH_ADD_EN
  logic              alu_carry;
  logic              tc_q, tc_d;      // carry captured in EXEC, published at WB
  logic              carry_q, carry_d;
`endif

  assign cmd_op_e  = op_e'(cmd_op);
  assign cmd_legal = (cmd_op_e == OP_LDI) || (cmd_op_e == OP_MOV) || is_alu_op(cmd_op_e);

  seq_datapath_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op_q),
    .a      (tmp_q),
    .b      (rf_rd(regs_q, rs_q)),
`ifdef SEQ_DATAPATH_ADD_EN
    .carry  (alu_carry),
`endif
    .result (alu_res)
  );

  always_comb begin
    state_d = state_q;
    regs_d  = regs_q;
    tmp_d   = tmp_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rs_d    = rs_q;
    eflag_d = eflag_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef SEQ_DATAPATH_ADD_EN
    tc_d    = tc_q;
    carry_d = carry_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op_e;
          rd_d    = cmd_rd;
          rs_d    = cmd_rs;
          eflag_d = 1'b0;
          if (!cmd_legal || !in_range(cmd_rd) || !in_range(cmd_rs)) begin
            eflag_d = 1'b1;
            state_d = WB;
          end else if (cmd_op_e == OP_LDI) begin
            tmp_d   = cmd_imm;
            state_d = WB;
          end else if (cmd_op_e == OP_MOV) begin
            tmp_d   = rf_rd(regs_q, cmd_rs);
            state_d = WB;
          end else begin
            state_d = LOAD_T;
          end
        end
      end
      LOAD_T: begin
        tmp_d   = rf_rd(regs_q, rd_q);
        state_d = EXEC;
      end
      EXEC: begin
        tmp_d   = alu_res;
`ifdef SEQ_DATAPATH_ADD_EN
        tc_d    = alu_carry;
`endif
        state_d = WB;
      end
      WB: begin
        if (!eflag_q) begin
          for (int i = 0; i < NREGS; i++)
            if (rd_q == IDX_W'(i)) regs_d[i] = tmp_q;
`ifdef SEQ_DATAPATH_ADD_EN
          if (op_q == OP_ADD) carry_d = tc_q;
`endif
        end
        done_d  = 1'b1;
        err_d   = eflag_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      regs_q  <= '0;
      tmp_q   <= '0;
      op_q    <= OP_LDI;
      rd_q    <= '0;
      rs_q    <= '0;
      eflag_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef SEQ_DATAPATH_ADD_EN
      tc_q    <= 1'b0;
      carry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
      tmp_q   <= tmp_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs_q    <= rs_d;
      eflag_q <= eflag_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef SEQ_DATAPATH_ADD_EN
      tc_q    <= tc_d;
      carry_q <= carry_d;
`endif
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign out       = regs_q[OUT_REG];
  assign dbg_data  = rf_rd(regs_q, dbg_idx);
`ifdef SEQ_DATAPATH_ADD_EN
  assign carry     = carry_q;
`endif

endmodule
